// File: rtl/multiples_sum_engine.sv
// Iterative sum/count of integers in [1, max-1] divisible by div_a or div_b, one candidate per clock.
// Optional abort input/aborted output when MULT_SUM_ABORT_EN is defined.
module multiples_sum_engine #(
    parameter int WIDTH = 32,
    parameter int DIV_W = 8,
    parameter int SUM_W = 64
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] max,
    input  logic [DIV_W-1:0] div_a,
    input  logic [DIV_W-1:0] div_b,
`ifdef MULT_SUM_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic [SUM_W-1:0] sum,
    output logic [WIDTH-1:0] match_count,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int AW = ((SUM_W > WIDTH) ? SUM_W : WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] max_q, c;
    logic [DIV_W-1:0] a_q, b_q, ra, rb;
    logic             load, add_en, advance, set_abort;

    // Residues track c mod div without a divider; they wrap to 0 on reaching the divisor.
    logic [DIV_W:0]   ra_inc, rb_inc;
    logic [DIV_W-1:0] ra_nxt, rb_nxt;
    logic             hit, last;
    logic [AW-1:0]    sum_ext;

    assign ra_inc  = {1'b0, ra} + 1'b1;
    assign rb_inc  = {1'b0, rb} + 1'b1;
    assign ra_nxt  = (ra_inc == {1'b0, a_q}) ? '0 : ra_inc[DIV_W-1:0];
    assign rb_nxt  = (rb_inc == {1'b0, b_q}) ? '0 : rb_inc[DIV_W-1:0];
    assign hit     = ((a_q != '0) && (ra == '0)) || ((b_q != '0) && (rb == '0));
    assign last    = (c == max_q - WIDTH'(1));
    assign sum_ext = AW'(sum) + AW'(c);

    always_comb begin
        state_d   = state;
        load      = 1'b0;
        add_en    = 1'b0;
        advance   = 1'b0;
        set_abort = 1'b0;
        case (state)
            IDLE: if (start) begin
                load    = 1'b1;
                state_d = RUN;
            end
            RUN: begin
`ifdef MULT_SUM_ABORT_EN
                if (abort) begin
                    set_abort = 1'b1;
                    state_d   = DONE;
                end else
`endif
                if (max_q <= WIDTH'(1)) begin
                    state_d = DONE;
                end else begin
                    add_en = hit;
                    if (last) state_d = DONE;
                    else      advance = 1'b1;
                end
            end
            DONE: if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            max_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c           <= '0;
            ra          <= '0;
            rb          <= '0;
            sum         <= '0;
            match_count <= '0;
            overflow    <= 1'b0;
        end else if (load) begin
            max_q       <= max;
            a_q         <= div_a;
            b_q         <= div_b;
            c           <= WIDTH'(1);
            ra          <= (div_a > DIV_W'(1)) ? DIV_W'(1) : '0;
            rb          <= (div_b > DIV_W'(1)) ? DIV_W'(1) : '0;
            sum         <= '0;
            match_count <= '0;
            overflow    <= 1'b0;
        end else begin
            if (add_en) begin
                sum         <= sum_ext[SUM_W-1:0];
                match_count <= match_count + WIDTH'(1);
                if (|sum_ext[AW-1:SUM_W]) overflow <= 1'b1;
            end
            if (advance) begin
                c  <= c + WIDTH'(1);
                ra <= ra_nxt;
                rb <= rb_nxt;
            end
        end
    end

`ifdef MULT_SUM_ABORT_EN
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n)       aborted <= 1'b0;
        else if (load)      aborted <= 1'b0;
        else if (set_abort) aborted <= 1'b1;
    end
`endif

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_multiples_sum_engine.sv
// Bench for multiples_sum_engine: a 64-bit-sum and an 8-bit-sum instance share stimulus and
// are checked each cycle against an exact-arithmetic model, plus hand-computed job results.
`timescale 1ns/1ps
module tb_multiples_sum_engine;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n  = 1'b1;
    logic        start    = 1'b0;
    logic [31:0] max      = '0;
    logic [7:0]  div_a    = '0;
    logic [7:0]  div_b    = '0;
    logic [63:0] sum64;
    logic [7:0]  sum8;
    logic [31:0] cnt64, cnt8;
    logic        ovf64, ovf8, busy64, busy8, done64, done8;
`ifdef MULT_SUM_ABORT_EN
    logic        abort = 1'b0;
    logic        aborted64, aborted8;
`endif

    always #5 CLOCK_50 = ~CLOCK_50;

    multiples_sum_engine #(.WIDTH(32), .DIV_W(8), .SUM_W(64)) dut64 (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start), .max(max),
        .div_a(div_a), .div_b(div_b),
`ifdef MULT_SUM_ABORT_EN
        .abort(abort), .aborted(aborted64),
`endif
        .sum(sum64), .match_count(cnt64), .overflow(ovf64), .busy(busy64), .done(done64));

    multiples_sum_engine #(.WIDTH(32), .DIV_W(8), .SUM_W(8)) dut8 (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start), .max(max),
        .div_a(div_a), .div_b(div_b),
`ifdef MULT_SUM_ABORT_EN
        .abort(abort), .aborted(aborted8),
`endif
        .sum(sum8), .match_count(cnt8), .overflow(ovf8), .busy(busy8), .done(done8));

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Model: phase 0 idle, 1 run, 2 done; exact sum kept unbounded-ish, widths applied on compare.
    int          m_ph = 0;
    int unsigned m_max = 0, m_a = 0, m_b = 0, m_k = 0, m_cnt = 0;
    longint unsigned m_exact = 0;
    bit          m_abt = 1'b0;

    always @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            m_ph <= 0; m_cnt <= 0; m_exact <= 0; m_abt <= 1'b0;
        end else begin
            case (m_ph)
                0: if (start) begin
                    m_max <= max; m_a <= div_a; m_b <= div_b; m_k <= 1;
                    m_cnt <= 0; m_exact <= 0; m_abt <= 1'b0; m_ph <= 1;
                end
                1: begin
`ifdef MULT_SUM_ABORT_EN
                    if (abort) begin
                        m_abt <= 1'b1; m_ph <= 2;
                    end else
`endif
                    if (m_max <= 1) m_ph <= 2;
                    else begin
                        if ((m_a != 0 && m_k % m_a == 0) || (m_b != 0 && m_k % m_b == 0)) begin
                            m_exact <= m_exact + m_k;
                            m_cnt   <= m_cnt + 1;
                        end
                        if (m_k == m_max - 1) m_ph <= 2;
                        else                  m_k  <= m_k + 1;
                    end
                end
                default: if (!start) m_ph <= 0;
            endcase
        end
    end

    always @(negedge CLOCK_50) begin
        if (cmp_en) begin
            chk("busy64", busy64, m_ph == 1);
            chk("done64", done64, m_ph == 2);
            chk("sum64",  sum64,  m_exact);
            chk("cnt64",  cnt64,  m_cnt);
            chk("ovf64",  ovf64,  1'b0);
            chk("busy8",  busy8,  m_ph == 1);
            chk("done8",  done8,  m_ph == 2);
            chk("sum8",   sum8,   m_exact % 256);
            chk("cnt8",   cnt8,   m_cnt);
            chk("ovf8",   ovf8,   m_exact > 255);
`ifdef MULT_SUM_ABORT_EN
            chk("aborted64", aborted64, m_abt);
            chk("aborted8",  aborted8,  m_abt);
`endif
        end
    end

    // Starts a job, scrambles the live inputs after E0, measures done latency in edges.
    task automatic run_job(input int unsigned mx, input int a, input int b,
                           input longint unsigned es, input int ec, input int hold);
        int n;
        int lat;
        lat = (mx < 2) ? 1 : int'(mx) - 1;
        max = mx; div_a = 8'(a); div_b = 8'(b); start = 1'b1;
        @(posedge CLOCK_50); #1;
        max = $urandom; div_a = 8'($urandom); div_b = 8'($urandom);
        n = 0;
        while (!done64 && n < 5000) begin
            @(posedge CLOCK_50); #1;
            n++;
        end
        chk($sformatf("latency_max%0d", mx), n, lat);
        chk($sformatf("sum_max%0d", mx), sum64, es);
        chk($sformatf("count_max%0d", mx), cnt64, ec);
        for (int i = 0; i < hold; i++) begin
            @(posedge CLOCK_50); #1;
            chk("done_held", done64, 1'b1);
            chk("no_restart", busy64, 1'b0);
            chk("sum_held", sum64, es);
        end
        start = 1'b0;
        @(posedge CLOCK_50); #1;
        chk("done_cleared", done64, 1'b0);
        chk("idle_sum_held", sum64, es);
    endtask

    initial begin
        #2 reset_n = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("rst_sum", sum64, 0);
        chk("rst_cnt", cnt64, 0);
        chk("rst_ovf", ovf64, 0);
        chk("rst_busy", busy64, 0);
        chk("rst_done", done64, 0);
        reset_n = 1'b1;
        cmp_en  = 1'b1;
        @(posedge CLOCK_50); #1;

        run_job(10, 3, 5, 23, 4, 3);
        chk("ovf_max10", ovf64, 0);
        run_job(1000, 3, 5, 233168, 466, 1);
        run_job(0, 3, 5, 0, 0, 1);
        run_job(1, 3, 5, 0, 0, 1);
        run_job(50, 0, 0, 0, 0, 1);
        run_job(10, 3, 3, 18, 3, 1);
        run_job(600, 255, 0, 765, 2, 1);
        run_job(100, 1, 0, 4950, 99, 1);
        chk("sum8_wrap", sum8, 86);
        chk("cnt8_wrap", cnt8, 99);
        chk("ovf8_set", ovf8, 1);
        run_job(10, 3, 5, 23, 4, 1);
        chk("ovf8_cleared", ovf8, 0);

        // Reset in the middle of a long job.
        max = 1000; div_a = 3; div_b = 5; start = 1'b1;
        @(posedge CLOCK_50); #1;
        repeat (5) @(posedge CLOCK_50);
        #1;
        chk("partial_sum_e5", sum64, 8);
        reset_n = 1'b0;
        #1;
        chk("midrst_sum", sum64, 0);
        chk("midrst_cnt", cnt64, 0);
        chk("midrst_busy", busy64, 0);
        chk("midrst_done", done64, 0);
        start = 1'b0;
        @(posedge CLOCK_50); #1;
        reset_n = 1'b1;
        @(posedge CLOCK_50); #1;
        run_job(10, 3, 5, 23, 4, 4);

`ifdef MULT_SUM_ABORT_EN
        max = 1000; div_a = 3; div_b = 5; start = 1'b1;
        @(posedge CLOCK_50); #1;
        repeat (10) @(posedge CLOCK_50);
        #1;
        abort = 1'b1;
        @(posedge CLOCK_50); #1;
        abort = 1'b0;
        chk("abort_done", done64, 1);
        chk("abort_sum", sum64, 33);
        chk("abort_cnt", cnt64, 5);
        chk("abort_flag", aborted64, 1);
        start = 1'b0;
        @(posedge CLOCK_50); #1;
        abort = 1'b1;
        @(posedge CLOCK_50); #1;
        abort = 1'b0;
        chk("abort_idle_ignored", busy64, 0);
        run_job(10, 3, 5, 23, 4, 1);
        chk("abort_flag_cleared", aborted64, 0);
`endif

        @(negedge CLOCK_50);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
